// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetches opcode bytes (and the target byte of
// two-byte jump instructions) from program memory, then strobes the decoder.
//
// state  | meaning
// IDLE   | one-cycle settle after reset release
// FETCH  | reading the opcode byte at pc
// EXEC   | decoder strobe; jump/hlt sampled here
// TARGET | reading the second byte of a two-byte instruction
// HALT   | stopped until reset
module fetch_seq #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       mreq,
    output logic [7:0] maddr,
    input  logic [7:0] mdata,
    input  logic       mack,
    output logic [3:0] ins,
    output logic [3:0] imm,
    output logic       exec,
    input  logic       jump,
    input  logic       hlt,
    output logic       halted,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_TARGET,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       jtake_q, jtake_d;
    logic       two_byte;

    // Opcodes 6..11 carry a target byte after the opcode.
    assign two_byte = (ir_q[7:4] >= 4'd6) && (ir_q[7:4] <= 4'd11);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            jtake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            jtake_q <= jtake_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        jtake_d = jtake_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mack) begin
                    ir_d    = mdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (hlt) begin
                    state_d = S_HALT;
                end else if (two_byte) begin
                    jtake_d = jump;
                    state_d = S_TARGET;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_TARGET: begin
                if (mack) begin
                    pc_d    = jtake_q ? mdata : pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mreq   = (state_q == S_FETCH) || (state_q == S_TARGET);
    assign maddr  = pc_q;
    assign exec   = (state_q == S_EXEC);
    assign halted = (state_q == S_HALT);
    assign ins    = ir_q[7:4];
    assign imm    = ir_q[3:0];
    assign pc     = pc_q;

endmodule
